// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch stage of the five-stage pipeline. The block owns the
// program counter and fetches from instruction memory over a req/ack
// handshake. Each fetched word is latched, together with its PC and PC+4,
// into the IF/ID pipeline register that feeds decode. A one-entry hold
// buffer absorbs decode back-pressure. Branch/jump redirects from later
// stages flush all wrong-path state and restart fetch at the target.
//
// Parameters
//   RESET_PC            PC loaded on reset; bits [1:0] must be 0
//
// Ports
//   i_clk               pipeline clock, all state updates on posedge
//   i_rst               asynchronous, active-high reset
//   o_imem_req          fetch request, held with stable address until ack
//   o_imem_addr         word-aligned fetch address
//   i_imem_ack          response strobe, rdata valid in the same cycle
//   i_imem_rdata        fetched instruction
//   i_id_stall          decode cannot accept this cycle
//   i_redirect_valid    one-cycle pulse: flush and refetch from i_redirect_pc
//   i_redirect_pc       redirect target; bits [1:0] forced to 0
//   o_if_id_valid       IF/ID register holds a valid instruction
//   o_if_id_instr       instruction word
//   o_if_id_pc          address of o_if_id_instr
//   o_if_id_pc_plus4    o_if_id_pc + 4, modulo 2^32
//
// Optional build macro IF_PERF_CNT_EN adds saturating performance counters:
//   o_perf_fetch_cnt    instructions loaded into IF/ID
//   o_perf_stall_cnt    cycles with a valid IF/ID entry held by decode stall
//   o_perf_flush_cnt    redirect pulses seen
//
// States
//   S_FETCH   | request at pc; on ack load IF/ID (or hold buffer if stalled)
//   S_HOLD    | no request; word parked in hold buffer until decode frees slot
//   S_DISCARD | re-present abandoned address until its ack, then drop rdata
// ---------------------------------------------------------------------------
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ack,
   input  logic [31:0] i_imem_rdata,
   input  logic        i_id_stall,
   input  logic        i_redirect_valid,
   input  logic [31:0] i_redirect_pc,
   output logic        o_if_id_valid,
   output logic [31:0] o_if_id_instr,
   output logic [31:0] o_if_id_pc,
   output logic [31:0] o_if_id_pc_plus4
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] o_perf_fetch_cnt,
   output logic [31:0] o_perf_stall_cnt,
   output logic [15:0] o_perf_flush_cnt
`endif
);

   typedef enum logic [1:0] {
      S_FETCH   = 2'd0,
      S_HOLD    = 2'd1,
      S_DISCARD = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_disc_addr;
   logic        r_hold_valid;
   logic [31:0] r_hold_instr;
   logic [31:0] r_hold_pc;
   logic        r_if_id_valid;
   logic [31:0] r_if_id_instr;
   logic [31:0] r_if_id_pc;
   logic [31:0] r_if_id_pc_plus4;

   logic        w_req;
   logic        w_ack;
   logic        w_slot_free;
   logic        w_consume;
   logic        w_load;
   logic [31:0] w_pc_plus4;
   logic [31:0] w_hold_pc_plus4;
   logic [31:0] w_redirect_pc;

   // Request is a decode of the registered state; reset gates it off
   // immediately so an in-flight request is abandoned without waiting.
   always_comb begin
      w_req           = (r_state != S_HOLD) && !i_rst;
      // An ack is only meaningful while a request is being presented.
      w_ack           = i_imem_ack && w_req;
      w_slot_free     = !r_if_id_valid || !i_id_stall;
      w_consume       = r_if_id_valid && !i_id_stall;
      w_pc_plus4      = r_pc + 32'd4;
      w_hold_pc_plus4 = r_hold_pc + 32'd4;
      w_redirect_pc   = i_redirect_pc & 32'hFFFF_FFFC;
      w_load          = 1'b0;
      if (!i_redirect_valid) begin
         if (r_state == S_FETCH)
            w_load = w_ack && w_slot_free;
         else if (r_state == S_HOLD)
            w_load = r_hold_valid && w_slot_free;
      end
   end

   assign o_imem_req       = w_req;
   assign o_imem_addr      = (r_state == S_DISCARD) ? r_disc_addr : r_pc;
   assign o_if_id_valid    = r_if_id_valid;
   assign o_if_id_instr    = r_if_id_instr;
   assign o_if_id_pc       = r_if_id_pc;
   assign o_if_id_pc_plus4 = r_if_id_pc_plus4;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state          <= S_FETCH;
         r_pc             <= RESET_PC;
         r_disc_addr      <= RESET_PC;
         r_hold_valid     <= 1'b0;
         r_hold_instr     <= 32'd0;
         r_hold_pc        <= 32'd0;
         r_if_id_valid    <= 1'b0;
         r_if_id_instr    <= 32'd0;
         r_if_id_pc       <= 32'd0;
         r_if_id_pc_plus4 <= 32'd0;
      end else if (i_redirect_valid) begin
         // Redirect outranks ack, stall and hold release.
         r_pc          <= w_redirect_pc;
         r_if_id_valid <= 1'b0;
         r_hold_valid  <= 1'b0;
         case (r_state)
            S_FETCH: begin
               if (w_ack) begin
                  // Request completed this cycle; its data is simply dropped.
                  r_state <= S_FETCH;
               end else begin
                  // Memory still owes an ack for the old address; keep
                  // presenting it so the handshake stays legal.
                  r_state     <= S_DISCARD;
                  r_disc_addr <= r_pc;
               end
            end
            S_HOLD:    r_state <= S_FETCH;
            S_DISCARD: r_state <= S_DISCARD;
            default:   r_state <= S_FETCH;
         endcase
      end else begin
         case (r_state)
            S_FETCH: begin
               if (w_ack) begin
                  r_pc <= w_pc_plus4;
                  if (w_slot_free) begin
                     r_if_id_valid    <= 1'b1;
                     r_if_id_instr    <= i_imem_rdata;
                     r_if_id_pc       <= r_pc;
                     r_if_id_pc_plus4 <= w_pc_plus4;
                  end else begin
                     r_hold_valid <= 1'b1;
                     r_hold_instr <= i_imem_rdata;
                     r_hold_pc    <= r_pc;
                     r_state      <= S_HOLD;
                  end
               end else if (w_consume) begin
                  r_if_id_valid <= 1'b0;
               end
            end
            S_HOLD: begin
               if (r_hold_valid && w_slot_free) begin
                  r_if_id_valid    <= 1'b1;
                  r_if_id_instr    <= r_hold_instr;
                  r_if_id_pc       <= r_hold_pc;
                  r_if_id_pc_plus4 <= w_hold_pc_plus4;
                  r_hold_valid     <= 1'b0;
                  r_state          <= S_FETCH;
               end
            end
            S_DISCARD: begin
               if (w_consume)
                  r_if_id_valid <= 1'b0;
               if (w_ack)
                  r_state <= S_FETCH;
            end
            default: r_state <= S_FETCH;
         endcase
      end
   end

`ifdef IF_PERF_CNT_EN
   logic [31:0] r_perf_fetch_cnt;
   logic [31:0] r_perf_stall_cnt;
   logic [15:0] r_perf_flush_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_perf_fetch_cnt <= 32'd0;
         r_perf_stall_cnt <= 32'd0;
         r_perf_flush_cnt <= 16'd0;
      end else begin
         if (w_load && (r_perf_fetch_cnt != 32'hFFFF_FFFF))
            r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
         if (r_if_id_valid && i_id_stall && (r_perf_stall_cnt != 32'hFFFF_FFFF))
            r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
         if (i_redirect_valid && (r_perf_flush_cnt != 16'hFFFF))
            r_perf_flush_cnt <= r_perf_flush_cnt + 16'd1;
      end
   end

   assign o_perf_fetch_cnt = r_perf_fetch_cnt;
   assign o_perf_stall_cnt = r_perf_stall_cnt;
   assign o_perf_flush_cnt = r_perf_flush_cnt;
`endif

endmodule
